// File: rtl/arb_mux_n.sv
// N-input registered mux with round-robin arbitration and valid/ready handshakes.
// Optional ARB_MUX_FORCE_SEL_EN adds force_en/force_sel to bypass the arbiter.
module arb_mux_n #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel
`ifdef ARB_MUX_FORCE_SEL_EN
  ,
  input  logic                    force_en,
  input  logic [SEL_W-1:0]        force_sel
`endif
);

  localparam int unsigned SEL_N    = 1 << SEL_W;
  localparam int unsigned LAST_RST = NUM_IN - 1;

  logic [SEL_W-1:0] last_q;
  logic [SEL_N-1:0] valid_pad;
  logic             load_c;
  logic             rr_vld;
  logic [SEL_W-1:0] rr_idx;
  logic             grant_vld_c;
  logic [SEL_W-1:0] grant_idx_c;
  logic [WIDTH-1:0] grant_data_c;

  logic             out_valid_d;
  logic [WIDTH-1:0] out_data_d;
  logic [SEL_W-1:0] out_sel_d;
  logic [SEL_W-1:0] last_d;

  // Zero-padded to the full index space so an out-of-range index reads as not valid.
  assign valid_pad = SEL_N'(in_valid);
  assign load_c    = !out_valid || out_ready;

  // Round-robin search starting just after the last granted channel.
  always_comb begin : rr_arb
    logic [SEL_W-1:0] cand;
    rr_vld = 1'b0;
    rr_idx = '0;
    cand   = '0;
    for (int unsigned i = 1; i <= NUM_IN; i++) begin
      cand = SEL_W'((32'(last_q) + i) % NUM_IN);
      if (!rr_vld && valid_pad[cand]) begin
        rr_vld = 1'b1;
        rr_idx = cand;
      end
    end
  end

  always_comb begin : grant_sel
    grant_vld_c = rr_vld;
    grant_idx_c = rr_idx;
`ifdef ARB_MUX_FORCE_SEL_EN
    if (force_en) begin
      grant_vld_c = valid_pad[force_sel];
      grant_idx_c = force_sel;
    end
`endif
  end

  always_comb begin : data_mux
    grant_data_c = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (grant_idx_c == SEL_W'(k)) begin
        grant_data_c = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin : ready_gen
    in_ready = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      in_ready[k] = !rst && load_c && grant_vld_c && (grant_idx_c == SEL_W'(k));
    end
  end

  always_comb begin : next_state
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_sel_d   = out_sel;
    last_d      = last_q;
    if (load_c) begin
      out_valid_d = grant_vld_c;
      if (grant_vld_c) begin
        out_data_d = grant_data_c;
        out_sel_d  = grant_idx_c;
        last_d     = grant_idx_c;
      end
    end
  end

  // Reset drops any held beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last_q    <= SEL_W'(LAST_RST);
    end else begin
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_sel   <= out_sel_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_arb_mux_n.sv
// Self-checking bench for arb_mux_n: scoreboarded 4-input instance plus a 3-input wrap instance.
module tb_arb_mux_n;

  localparam int N = 4;
  localparam int W = 16;

  logic          clk;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [N*W-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    out_sel;

  logic [2:0]    in_valid3;
  logic [2:0]    in_ready3;
  logic [23:0]   in_data3;
  logic          out_valid3;
  logic          out_ready3;
  logic [7:0]    out_data3;
  logic [1:0]    out_sel3;

`ifdef ARB_MUX_FORCE_SEL_EN
  logic          force_en;
  logic [1:0]    force_sel;
  logic          force_en3;
  logic [1:0]    force_sel3;
`endif

  int checks;
  int failures;

  typedef struct {
    int         sel;
    logic [W-1:0] data;
  } beat_t;

  beat_t q[$];
  int    m_last;

  arb_mux_n #(.WIDTH(W), .NUM_IN(N)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
`ifdef ARB_MUX_FORCE_SEL_EN
    ,
    .force_en  (force_en),
    .force_sel (force_sel)
`endif
  );

  arb_mux_n #(.WIDTH(8), .NUM_IN(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .in_data   (in_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_data  (out_data3),
    .out_sel   (out_sel3)
`ifdef ARB_MUX_FORCE_SEL_EN
    ,
    .force_en  (force_en3),
    .force_sel (force_sel3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_data(input int k, input logic [W-1:0] v);
    in_data[k*W +: W] = v;
  endtask

  // Reference arbiter: scan upward from m_last+1, then wrap to 0..m_last.
  function automatic int model_grant();
    int g;
    g = -1;
`ifdef ARB_MUX_FORCE_SEL_EN
    if (force_en) begin
      if (int'(force_sel) < N && in_valid[force_sel]) g = int'(force_sel);
      return g;
    end
`endif
    for (int k = m_last + 1; k < N; k++) if (g < 0 && in_valid[k]) g = k;
    for (int k = 0; k <= m_last; k++) if (g < 0 && in_valid[k]) g = k;
    return g;
  endfunction

  // One clock: compare at negedge, advance scoreboard, return at posedge+1.
  task automatic step();
    int         g;
    logic       load;
    logic [N-1:0] exp_rdy;
    beat_t      b;
    @(negedge clk);
    g       = model_grant();
    load    = (q.size() == 0) || out_ready;
    exp_rdy = '0;
    if (!rst && load && g >= 0) exp_rdy[g] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_sel", 32'(out_sel), 32'(q[0].sel));
      check("out_data", 32'(out_data), 32'(q[0].data));
    end
    if (rst) begin
      q.delete();
      m_last = N - 1;
    end else if (load) begin
      if (q.size() != 0) void'(q.pop_front());
      if (g >= 0) begin
        b.sel  = g;
        b.data = in_data[g*W +: W];
        q.push_back(b);
        m_last = g;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    m_last    = N - 1;
    rst       = 1'b1;
    in_valid  = '1;
    in_data   = '0;
    out_ready = 1'b1;
    in_valid3 = '0;
    in_data3  = {8'hA2, 8'hA1, 8'hA0};
    out_ready3 = 1'b1;
`ifdef ARB_MUX_FORCE_SEL_EN
    force_en   = 1'b0;
    force_sel  = '0;
    force_en3  = 1'b0;
    force_sel3 = '0;
`endif
    @(posedge clk);
    #1;

    // T1 reset with all channels requesting
    step();
    step();
    rst      = 1'b0;
    in_valid = '0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);

    // T3 fairness: 0,1,2,3,0,1,2,3 with no bubbles
    for (int k = 0; k < N; k++) set_data(k, W'(k << 4));
    in_valid = '1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_seq_sel", 32'(out_sel), 32'(i % N));
      check("rr_seq_data", 32'(out_data), 32'((i % N) << 4));
    end

    // T2 single requester
    in_valid = 4'b0100;
    set_data(2, 16'hBEEF);
    #1;
    check("single_ready", 32'(in_ready), 32'b0100);
    step();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'hBEEF);
    check("single_sel", 32'(out_sel), 32'd2);

    // T4 backpressure with out_sel=1 held
    in_valid = 4'b0010;
    step();
    in_valid  = '1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_sel", 32'(out_sel), 32'd1);
      check("bp_data", 32'(out_data), 32'h0010);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'b0100);
    step();
    check("bp_release_sel", 32'(out_sel), 32'd2);

    // T5 reset while a beat is held
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    step();
    check("midrst_first_sel", 32'(out_sel), 32'd0);
    in_valid = '0;
    step();

    // Non-power-of-2 wrap on the 3-input instance
    in_valid3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      step();
      check("n3_sel", 32'(out_sel3), 32'(i % 3));
      check("n3_data", 32'(out_data3), 32'(8'hA0 + 8'(i % 3)));
    end
    in_valid3 = '0;
    step();
    check("n3_drain", 32'(out_valid3), 32'd0);

`ifdef ARB_MUX_FORCE_SEL_EN
    // T6 forced selection
    force_en  = 1'b1;
    force_sel = 2'd3;
    in_valid  = '1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("force_sel", 32'(out_sel), 32'd3);
    end
    force_en = 1'b0;
    in_valid = '0;
    step();
    force_en3  = 1'b1;
    force_sel3 = 2'd3;
    in_valid3  = 3'b111;
    #1;
    check("force_oor_ready", 32'(in_ready3), 32'd0);
    step();
    step();
    check("force_oor_valid", 32'(out_valid3), 32'd0);
    force_en3 = 1'b0;
    in_valid3 = '0;
    step();
`endif

    // Random traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < N; k++) set_data(k, W'($urandom));
      step();
    end
    rst      = 1'b0;
    in_valid = '0;
    out_ready = 1'b1;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
